// File: rtl/updi_responder.sv
//==============================================================================
// Module      : updi_responder
// Description : UPDI-style target responder: sync/opcode decode, LDS/STS memory
//               access and LDCS/STCS control-status access over byte FIFOs.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module updi_responder #(
    parameter int MEM_BYTES     = 256,
    parameter int MEM_ADDR_BITS = $clog2(MEM_BYTES)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_fifo_data,
    input  logic       rx_fifo_empty,
    output logic       rx_fifo_rd_en,
    output logic [7:0] tx_fifo_data,
    output logic       tx_fifo_wr_en,
    input  logic       tx_fifo_full,
    output logic       busy,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_OPCODE   = 3'd1,
        S_ADDR     = 3'd2,
        S_ACK_ADDR = 3'd3,
        S_DATA_IN  = 3'd4,
        S_ACK_DATA = 3'd5,
        S_DATA_OUT = 3'd6,
        S_CS_DATA  = 3'd7
    } state_t;

    localparam logic [1:0] c_KIND_LDS  = 2'b00;
    localparam logic [1:0] c_KIND_STS  = 2'b01;
    localparam logic [1:0] c_KIND_LDCS = 2'b10;
    localparam logic [7:0] c_SYNC      = 8'h55;
    localparam logic [7:0] c_ACK       = 8'h40;

    state_t             r_state, w_state_nxt;
    logic               r_fetch, w_fetch_nxt;
    logic [1:0]         r_kind, w_kind_nxt;
    logic [1:0]         r_size_a, w_size_a_nxt;
    logic [1:0]         r_size_b, w_size_b_nxt;
    logic [1:0]         r_count, w_count_nxt;
    logic [15:0]        r_addr, w_addr_nxt;
    logic [3:0]         r_cs_addr, w_cs_addr_nxt;
    logic [7:0]         r_cs [16];
    logic [7:0]         r_mem [MEM_BYTES];
    logic               w_mem_we;
    logic               w_cs_we;
    logic               w_rx_state;
    logic [MEM_ADDR_BITS-1:0] w_idx;

    // The wire address is up to 16 bits; only its low bits select a byte.
    assign w_idx = MEM_ADDR_BITS'((32'(r_addr) + 32'(r_count)) % MEM_BYTES);

    assign busy = (r_state != S_IDLE);

    assign w_rx_state = (r_state == S_IDLE)    || (r_state == S_OPCODE) ||
                        (r_state == S_ADDR)    || (r_state == S_DATA_IN) ||
                        (r_state == S_CS_DATA);

    always_comb begin
        w_state_nxt   = r_state;
        w_fetch_nxt   = r_fetch;
        w_kind_nxt    = r_kind;
        w_size_a_nxt  = r_size_a;
        w_size_b_nxt  = r_size_b;
        w_count_nxt   = r_count;
        w_addr_nxt    = r_addr;
        w_cs_addr_nxt = r_cs_addr;
        w_mem_we      = 1'b0;
        w_cs_we       = 1'b0;
        rx_fifo_rd_en = 1'b0;
        tx_fifo_wr_en = 1'b0;
        tx_fifo_data  = 8'h00;
        err           = 1'b0;

        // Receive states alternate a pop cycle and a capture cycle.
        if (w_rx_state) begin
            if (!r_fetch) begin
                rx_fifo_rd_en = rst_n && !rx_fifo_empty;
                w_fetch_nxt   = !rx_fifo_empty;
            end else begin
                w_fetch_nxt = 1'b0;
            end
        end

        case (r_state)
            S_IDLE: begin
                if (r_fetch && rx_fifo_data == c_SYNC)
                    w_state_nxt = S_OPCODE;
            end
            S_OPCODE: begin
                if (r_fetch) begin
                    case (rx_fifo_data[7:5])
                        3'b000, 3'b010: begin
                            if (rx_fifo_data[3] || rx_fifo_data[1]) begin
                                err         = 1'b1;
                                w_state_nxt = S_IDLE;
                            end else begin
                                w_kind_nxt   = rx_fifo_data[7:6];
                                w_size_a_nxt = rx_fifo_data[3:2];
                                w_size_b_nxt = rx_fifo_data[1:0];
                                w_count_nxt  = 2'd0;
                                w_addr_nxt   = 16'h0000;
                                w_state_nxt  = S_ADDR;
                            end
                        end
                        3'b100: begin
                            w_kind_nxt    = c_KIND_LDCS;
                            w_cs_addr_nxt = rx_fifo_data[3:0];
                            w_count_nxt   = 2'd0;
                            w_state_nxt   = S_DATA_OUT;
                        end
                        3'b110: begin
                            w_kind_nxt    = rx_fifo_data[7:6];
                            w_cs_addr_nxt = rx_fifo_data[3:0];
                            w_state_nxt   = S_CS_DATA;
                        end
                        default: begin
                            err         = 1'b1;
                            w_state_nxt = S_IDLE;
                        end
                    endcase
                end
            end
            S_ADDR: begin
                if (r_fetch) begin
                    if (r_count == 2'd0)
                        w_addr_nxt[7:0] = rx_fifo_data;
                    else
                        w_addr_nxt[15:8] = rx_fifo_data;
                    if (r_count == r_size_a) begin
                        w_count_nxt = 2'd0;
                        w_state_nxt = (r_kind == c_KIND_STS) ? S_ACK_ADDR : S_DATA_OUT;
                    end else begin
                        w_count_nxt = r_count + 2'd1;
                    end
                end
            end
            S_ACK_ADDR: begin
                tx_fifo_data = c_ACK;
                if (!tx_fifo_full) begin
                    tx_fifo_wr_en = 1'b1;
                    w_state_nxt   = S_DATA_IN;
                end
            end
            S_DATA_IN: begin
                if (r_fetch) begin
                    w_mem_we = 1'b1;
                    if (r_count == r_size_b) begin
                        w_count_nxt = 2'd0;
                        w_state_nxt = S_ACK_DATA;
                    end else begin
                        w_count_nxt = r_count + 2'd1;
                    end
                end
            end
            S_ACK_DATA: begin
                tx_fifo_data = c_ACK;
                if (!tx_fifo_full) begin
                    tx_fifo_wr_en = 1'b1;
                    w_state_nxt   = S_IDLE;
                end
            end
            S_DATA_OUT: begin
                tx_fifo_data = (r_kind == c_KIND_LDCS) ? r_cs[r_cs_addr] : r_mem[w_idx];
                if (!tx_fifo_full) begin
                    tx_fifo_wr_en = 1'b1;
                    if (r_kind == c_KIND_LDCS || r_count == r_size_b) begin
                        w_count_nxt = 2'd0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_count_nxt = r_count + 2'd1;
                    end
                end
            end
            S_CS_DATA: begin
                if (r_fetch) begin
                    w_cs_we     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_fetch   <= 1'b0;
            r_kind    <= c_KIND_LDS;
            r_size_a  <= 2'd0;
            r_size_b  <= 2'd0;
            r_count   <= 2'd0;
            r_addr    <= 16'h0000;
            r_cs_addr <= 4'h0;
            for (int i = 0; i < 16; i++)
                r_cs[i] <= 8'h00;
        end else begin
            r_state   <= w_state_nxt;
            r_fetch   <= w_fetch_nxt;
            r_kind    <= w_kind_nxt;
            r_size_a  <= w_size_a_nxt;
            r_size_b  <= w_size_b_nxt;
            r_count   <= w_count_nxt;
            r_addr    <= w_addr_nxt;
            r_cs_addr <= w_cs_addr_nxt;
            if (w_cs_we)
                r_cs[r_cs_addr] <= rx_fifo_data;
        end
    end

    // Target memory deliberately has no reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (w_mem_we)
            r_mem[w_idx] <= rx_fifo_data;
    end

endmodule

`default_nettype wire

// File: tb/tb_updi_responder.sv
//==============================================================================
// Module      : tb_updi_responder
// Description : Table-driven, scoreboarded bench for updi_responder.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_updi_responder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_fifo_data = 8'h00;
    logic       rx_fifo_empty = 1'b1;
    logic       rx_fifo_rd_en;
    logic [7:0] tx_fifo_data;
    logic       tx_fifo_wr_en;
    logic       tx_fifo_full = 1'b0;
    logic       busy;
    logic       err;

    int n_vec = 0;
    int n_bad = 0;
    int err_seen = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    updi_responder #(.MEM_BYTES(256)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_fifo_data  (rx_fifo_data),
        .rx_fifo_empty (rx_fifo_empty),
        .rx_fifo_rd_en (rx_fifo_rd_en),
        .tx_fifo_data  (tx_fifo_data),
        .tx_fifo_wr_en (tx_fifo_wr_en),
        .tx_fifo_full  (tx_fifo_full),
        .busy          (busy),
        .err           (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] rx;     // bytes in send order, left-justified
        int          n_rx;
        logic [15:0] tx;     // expected bytes in order, left-justified
        int          n_tx;
        int          n_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // RX FIFO model: inputs sampled mid-cycle hold until the edge, so the pop
    // decision is taken there and the popped byte appears just after the edge.
    initial begin
        logic pop_now;
        forever begin
            @(negedge clk);
            pop_now = rx_fifo_rd_en && !rx_fifo_empty;
            @(posedge clk);
            #1;
            if (pop_now)
                rx_fifo_data = rx_q.pop_front();
            rx_fifo_empty = (rx_q.size() == 0);
        end
    end

    // TX scoreboard and err pulse counter.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_fifo_wr_en) begin
                if (tx_fifo_full)
                    check("wr_en_while_full", 32'(tx_fifo_wr_en), 32'd0);
                else if (exp_q.size() == 0)
                    check("unexpected_tx", 32'(tx_fifo_data), 32'hFFFF_FFFF);
                else
                    check("tx_byte", 32'(tx_fifo_data), 32'(exp_q.pop_front()));
            end
            if (err)
                err_seen++;
        end
    end

    task automatic wait_done(input string name, input int budget);
        int stable = 0;
        int cyc = 0;
        while (stable < 3 && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (rx_q.size() == 0 && rx_fifo_empty && !busy && exp_q.size() == 0)
                stable++;
            else
                stable = 0;
        end
        if (stable < 3)
            check({name, "_timeout"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic push_rx(input logic [47:0] rx, input int n);
        for (int j = 0; j < n; j++)
            rx_q.push_back(rx[47 - 8*j -: 8]);
    endtask

    task automatic push_exp(input logic [15:0] tx, input int n);
        for (int j = 0; j < n; j++)
            exp_q.push_back(tx[15 - 8*j -: 8]);
    endtask

    vec_t vecs[15];

    initial begin
        int err_base;
        int wr_during_hold;

        vecs[0]  = '{48'h55_45_12_34_56_78, 6, 16'h40_40, 2, 0};
        vecs[1]  = '{48'h55_05_12_34_00_00, 4, 16'h56_78, 2, 0};
        vecs[2]  = '{48'h55_40_FF_9C_00_00, 4, 16'h40_40, 2, 0};
        vecs[3]  = '{48'h55_40_00_3B_00_00, 4, 16'h40_40, 2, 0};
        vecs[4]  = '{48'hAA_00_55_00_FF_00, 5, 16'h9C_00, 1, 0};
        vecs[5]  = '{48'h55_01_FF_00_00_00, 3, 16'h9C_3B, 2, 0};
        vecs[6]  = '{48'h55_20_00_00_00_00, 2, 16'h00_00, 0, 1};
        vecs[7]  = '{48'h55_C3_A5_55_83_00, 5, 16'hA5_00, 1, 0};
        vecs[8]  = '{48'h55_0A_00_00_00_00, 2, 16'h00_00, 0, 1};
        vecs[9]  = '{48'h55_E1_00_00_00_00, 2, 16'h00_00, 0, 1};
        vecs[10] = '{48'h55_41_FF_AB_CD_00, 5, 16'h40_40, 2, 0};
        vecs[11] = '{48'h55_01_FF_00_00_00, 3, 16'hAB_CD, 2, 0};
        vecs[12] = '{48'h55_44_34_12_77_00, 5, 16'h40_40, 2, 0};
        vecs[13] = '{48'h55_04_34_99_00_00, 4, 16'h77_00, 1, 0};
        vecs[14] = '{48'h55_85_00_00_00_00, 2, 16'h00_00, 1, 0};

        // Reset state, with a byte waiting so rd_en gating is exercised.
        rx_q.push_back(8'hAA);
        repeat (4) @(posedge clk);
        #2;
        check("reset_rd_en", 32'(rx_fifo_rd_en), 32'd0);
        check("reset_wr_en", 32'(tx_fifo_wr_en), 32'd0);
        check("reset_busy",  32'(busy), 32'd0);
        check("reset_err",   32'(err), 32'd0);
        check("reset_txd",   32'(tx_fifo_data), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_done("junk_after_reset", 50);

        for (int i = 0; i < 15; i++) begin
            err_base = err_seen;
            push_exp(vecs[i].tx, vecs[i].n_tx);
            push_rx(vecs[i].rx, vecs[i].n_rx);
            wait_done($sformatf("vec%0d", i), 300);
            check($sformatf("vec%0d_err_pulses", i), 32'(err_seen - err_base), 32'(vecs[i].n_err));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
        end

        // Backpressure across an LDS word response.
        @(posedge clk); #1;
        tx_fifo_full = 1'b1;
        push_exp(16'h56_78, 2);
        push_rx(48'h55_05_12_34_00_00, 4);
        wr_during_hold = 0;
        repeat (24) begin
            @(negedge clk);
            if (tx_fifo_wr_en) wr_during_hold++;
        end
        check("hold_wr_en_count", 32'(wr_during_hold), 32'd0);
        check("hold_busy", 32'(busy), 32'd1);
        check("hold_pending", 32'(exp_q.size()), 32'd2);
        @(posedge clk); #1;
        tx_fifo_full = 1'b0;
        wait_done("bp_release", 100);

        // Reset in the middle of an STS address phase.
        push_rx(48'h55_45_12_00_00_00, 3);
        repeat (12) @(posedge clk);
        #1;
        check("mid_busy_before_reset", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #2;
        check("mid_reset_busy",  32'(busy), 32'd0);
        check("mid_reset_wr_en", 32'(tx_fifo_wr_en), 32'd0);
        check("mid_reset_rd_en", 32'(rx_fifo_rd_en), 32'd0);
        check("mid_reset_txd",   32'(tx_fifo_data), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_exp(16'h00_00, 1);
        push_rx(48'h55_84_00_00_00_00, 2);
        wait_done("post_reset_ldcs4", 100);
        push_exp(16'h00_00, 1);
        push_rx(48'h55_83_00_00_00_00, 2);
        wait_done("post_reset_ldcs3", 100);
        push_exp(16'h56_00, 1);
        push_rx(48'h55_00_12_00_00_00, 3);
        wait_done("mem_preserved", 100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/updi_responder.md
UPDI_RESPONDER -- requirements
Module: updi_responder

Interface
REQ-001 Parameter MEM_BYTES, default 256, power of two, size of the internal target data memory in bytes.
REQ-002 Parameter MEM_ADDR_BITS, default $clog2(MEM_BYTES), memory index width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 rx_fifo_data  input  8  byte from the initiator-side FIFO, registered: valid the cycle after a pop.
REQ-006 rx_fifo_empty  input  1  high when the RX FIFO holds no byte.
REQ-007 rx_fifo_rd_en  output  1  pops one RX byte at the edge where it is high and rx_fifo_empty=0.
REQ-008 tx_fifo_data  output  8  response byte toward the initiator.
REQ-009 tx_fifo_wr_en  output  1  pushes tx_fifo_data at the edge; never high while tx_fifo_full=1.
REQ-010 tx_fifo_full  input  1  TX FIFO cannot accept a byte.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 err  output  1  one-cycle pulse on protocol error.

Function
REQ-013 States: IDLE, OPCODE, ADDR, ACK_ADDR, DATA_IN, ACK_DATA, DATA_OUT, CS_DATA.
- Every byte fetch is one pop cycle plus one capture cycle.
REQ-014 IDLE: pop bytes; 0x55 -> OPCODE; any other byte discarded silently, no err.
REQ-015 OPCODE decode on bits[7:5]:
- 000 = LDS; 010 = STS: size_a=bits[3:2], size_b=bits[1:0].
- 100 = LDCS; 110 = STCS: cs_addr=bits[3:0].
- Any other opcode, or size_a/size_b > 01: err pulse, -> IDLE.
REQ-016 ADDR captures size_a+1 address bytes, little-endian (first byte = low); memory index = address mod MEM_BYTES.
REQ-017 LDS, after address: DATA_OUT emits mem[idx] .. mem[idx+size_b], ascending; no ACK.
REQ-018 STS, after address: ACK_ADDR pushes 0x40, then DATA_IN.
REQ-019 STS DATA_IN captures size_b+1 bytes; byte k written to mem[idx+k] in its capture cycle; then ACK_DATA pushes 0x40 -> IDLE.
REQ-020 LDCS: DATA_OUT emits cs[cs_addr] -> IDLE.
REQ-021 STCS: CS_DATA captures one byte into cs[cs_addr], no response -> IDLE.
REQ-022 Index arithmetic is MEM_ADDR_BITS wide; idx+k wraps modulo MEM_BYTES.
REQ-023 Backpressure: while tx_fifo_full=1, tx_fifo_wr_en=0 and the pending byte and state are held; emission resumes the first cycle full=0. No byte is lost or duplicated.
REQ-024 RX empty: while rx_fifo_empty=1, rx_fifo_rd_en=0 and state is held. No timeout.
REQ-025 At most one TX push per cycle; LDS word responses take at least 2 cycles.
REQ-026 Return to IDLE completes in the cycle after the last push or capture; a 0x55 already queued is popped that cycle.

Reset
REQ-027 While rst_n=0: state IDLE; rx_fifo_rd_en, tx_fifo_wr_en, busy and err = 0; tx_fifo_data = 0x00; address and count registers 0; all 16 cs registers 0x00.
REQ-028 Memory contents are not reset and are preserved across reset.
REQ-029 Reset asserted mid-transaction abandons it with no further pushes; after release, the next byte is treated as a sync candidate.

Verification
REQ-030 RX 55 45 12 34 56 78 -> TX 40 after byte 0x34, 40 after 0x78, exactly 2 pushes; mem[0x12]=0x56, mem[0x13]=0x78 (MEM_BYTES=256).
REQ-031 Following REQ-030, RX 55 05 12 34 -> TX 56 78, no ACK, busy low afterward.
REQ-032 RX AA 00 55 00 FF (byte address 0xFF, byte data) -> AA and 00 discarded, TX exactly mem[0xFF].
- Then 55 01 FF -> TX mem[0xFF], mem[0x00] (wrap).
REQ-033 Hold tx_fifo_full=1 for 10 cycles during the REQ-031 response -> wr_en stays 0; after release TX still 56 78 in order.
REQ-034 RX 55 20 -> err high exactly one cycle, no TX.
- Then 55 C3 A5 55 83 -> TX A5.
REQ-035 Assert rst_n=0 after RX 55 45 12 -> outputs at reset values, cs registers 0.
- After release, 55 84 -> TX 00.
